// File: rtl/data_bus_endpoint_fifo.sv
// data_bus_endpoint_fifo: shared tri-state bus endpoint with TX/RX FIFOs,
// destination/source addressing and a receiver-driven ready handshake.
// Optional feature macro: DATA_BUS_LOOPBACK_EN
//   defined   -> self-addressed TX heads loop straight into the local RX FIFO
//   undefined -> self-addressed TX heads are discarded and counted in drop_cnt
module data_bus_endpoint_fifo #(
  parameter int DATA_W   = 8,
  parameter int ID_W     = 2,
  parameter int MY_ID    = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic [ID_W-1:0]             tx_dest,
  output logic                        tx_ready,
  output logic                        rx_valid,
  output logic [DATA_W-1:0]           rx_data,
  output logic [ID_W-1:0]             rx_src,
  input  logic                        rx_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [7:0]                  drop_cnt,
  output logic                        bus_req,
  input  logic                        bus_grant,
  inout  wire  [DATA_W-1:0]           bus_data,
  inout  wire  [ID_W-1:0]             bus_dest,
  inout  wire  [ID_W-1:0]             bus_src,
  inout  wire                         bus_valid,
  inout  wire                         bus_ready
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [ID_W-1:0] SELF_ID     = ID_W'(MY_ID);
  localparam logic [TX_AW:0]  TX_FULL_LVL = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [RX_AW:0]  RX_FULL_LVL = (RX_AW + 1)'(RX_DEPTH);

  // One FIFO entry: the id field is the destination in TX and the source in RX.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t            tx_mem [TX_DEPTH];
  beat_t            rx_mem [RX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [RX_AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [TX_AW:0]   tx_level_reg;
  logic [RX_AW:0]   rx_level_reg;
  logic [7:0]       drop_cnt_reg;

  logic  tx_empty, tx_full, rx_empty, rx_full;
  logic  tx_push, tx_pop, rx_push, rx_pop;
  logic  tx_pop_bus, rx_push_bus;
  logic  head_self, drv, resp, xfer, drop_inc;
  beat_t tx_head, rx_head, rx_wdata;

  assign tx_empty = (tx_level_reg == '0);
  assign tx_full  = (tx_level_reg == TX_FULL_LVL);
  assign rx_empty = (rx_level_reg == '0);
  assign rx_full  = (rx_level_reg == RX_FULL_LVL);

  // Heads are read asynchronously so a granted beat reaches the bus with no added latency.
  assign tx_head   = tx_mem[tx_rd_ptr_reg];
  assign rx_head   = rx_mem[rx_rd_ptr_reg];
  assign head_self = !tx_empty && (tx_head.id == SELF_ID);

  // Sender side: drive only when granted with a head addressed elsewhere.
  assign drv  = bus_grant && !tx_empty && !rst && (tx_head.id != SELF_ID);
  // Receiver side: answer only a valid beat addressed to us while we are not the sender.
  assign resp = !bus_grant && (bus_valid === 1'b1) && (bus_dest == SELF_ID) && !rst;
  // Anything other than a clean 1 on valid/ready (0, z, x) means no transfer.
  assign xfer = (bus_valid === 1'b1) && (bus_ready === 1'b1);

  assign bus_data  = drv  ? tx_head.data : {DATA_W{1'bz}};
  assign bus_dest  = drv  ? tx_head.id   : {ID_W{1'bz}};
  assign bus_src   = drv  ? SELF_ID      : {ID_W{1'bz}};
  assign bus_valid = drv  ? 1'b1         : 1'bz;
  assign bus_ready = resp ? !rx_full     : 1'bz;

  assign tx_pop_bus  = drv && xfer;
  assign rx_push_bus = resp && xfer && !rx_full;

`ifdef DATA_BUS_LOOPBACK_EN
  logic lb_move;
  // A bus push takes the RX write port first; the loopback simply retries next cycle.
  assign lb_move  = head_self && !rx_full && !rx_push_bus;
  assign drop_inc = 1'b0;
  assign bus_req  = !tx_empty && !head_self;
  assign tx_pop   = tx_pop_bus || lb_move;
  assign rx_push  = rx_push_bus || lb_move;
  assign rx_wdata = rx_push_bus ? beat_t'{id: bus_src, data: bus_data}
                                : beat_t'{id: SELF_ID, data: tx_head.data};
`else
  // A self-addressed head can never be delivered, so it is dropped and counted.
  assign drop_inc = head_self;
  assign bus_req  = !tx_empty;
  assign tx_pop   = tx_pop_bus || head_self;
  assign rx_push  = rx_push_bus;
  assign rx_wdata = beat_t'{id: bus_src, data: bus_data};
`endif

  assign tx_push = tx_valid && !tx_full;
  assign rx_pop  = rx_ready && !rx_empty;

  // FIFO storage writes; contents need no reset because pointers and levels gate validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= beat_t'{id: tx_dest, data: tx_data};
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_wdata;
  end

  // Pointer, occupancy and drop-counter bookkeeping; pointers wrap modulo the depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      tx_level_reg  <= '0;
      rx_level_reg  <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
      tx_level_reg <= tx_level_reg + (TX_AW + 1)'(tx_push) - (TX_AW + 1)'(tx_pop);
      rx_level_reg <= rx_level_reg + (RX_AW + 1)'(rx_push) - (RX_AW + 1)'(rx_pop);
      if (drop_inc && (drop_cnt_reg != 8'hFF)) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_head.data;
  assign rx_src   = rx_head.id;
  assign tx_level = tx_level_reg;
  assign rx_level = rx_level_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule
